// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for alu_seq.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NOTA  = 4'd2;
  localparam logic [3:0] OP_NOR   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NAND  = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_SLT   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REMU  = 4'd14;
  localparam logic [3:0] OP_PASSB = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  function automatic logic is_iterative(input logic [3:0] sel);
    return (sel == OP_MUL) || (sel == OP_DIVU) || (sel == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider, one step per cycle for WIDTH cycles.
// done_o/result_o are valid during the final step so the caller registers them on that edge.
module alu_muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic             busy_q;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q;   // product accumulator / partial remainder
  logic [WIDTH-1:0] sh_q;    // multiplier shifting right / dividend becoming quotient
  logic [WIDTH-1:0] opb_q;   // multiplicand shifting left / fixed divisor

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  always_comb begin
    mul_acc  = acc_q + (sh_q[0] ? opb_q : '0);
    rem_sh   = {acc_q, sh_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    // A zero divisor never borrows, which yields all-ones quotient and remainder = A.
    q_bit    = ~rem_diff[WIDTH];
    rem_nxt  = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt  = {sh_q[WIDTH-2:0], q_bit};
    result_o = (op_q == OP_MUL)  ? mul_acc :
               (op_q == OP_DIVU) ? quo_nxt : rem_nxt;
    done_o   = busy_q && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      op_q   <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      opb_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      op_q   <= op_i;
      cnt_q  <= CNT_LAST;
      acc_q  <= '0;
      sh_q   <= a_i;
      opb_q  <= b_i;
    end else if (busy_q) begin
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
      if (op_q == OP_MUL) begin
        acc_q <= mul_acc;
        sh_q  <= sh_q >> 1;
        opb_q <= opb_q << 1;
      end else begin
        acc_q <= rem_nxt;
        sh_q  <= quo_nxt;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare ops, WIDTH-cycle mul/div/rem.
// Result and flags are registered; in_ready depends combinationally only on out_ready.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Negative,
  output logic             Zero,
  output logic             Overflow
);

  state_t           state_q;
  logic [WIDTH-1:0] y_q;
  logic             cout_q, neg_q, zero_q, ovf_q;

  logic             accept;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;

  logic [WIDTH:0]   add_sum, sub_sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] y_d;
  logic             cout_d, ovf_d;

  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid  = (state_q == ST_DONE);
  assign accept     = in_valid && in_ready;
  assign iter_start = accept && is_iterative(sel);

  assign Y        = y_q;
  assign Cout     = cout_q;
  assign Negative = neg_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

  alu_muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (iter_start),
    .op_i     (sel),
    .a_i      (A),
    .b_i      (B),
    .done_o   (iter_done),
    .result_o (iter_res)
  );

  always_comb begin
    add_sum = {1'b0, A} + {1'b0, B} + (WIDTH+1)'(Cin);
    sub_sum = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    shamt   = B[SHW-1:0];
    y_d     = '0;
    cout_d  = 1'b0;
    ovf_d   = 1'b0;
    case (sel)
      OP_AND:   y_d = A & B;
      OP_OR:    y_d = A | B;
      OP_NOTA:  y_d = ~A;
      OP_NOR:   y_d = ~(A | B);
      OP_XOR:   y_d = A ^ B;
      OP_NAND:  y_d = ~(A & B);
      OP_ADD: begin
        y_d    = add_sum[WIDTH-1:0];
        cout_d = add_sum[WIDTH];
        ovf_d  = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        y_d    = sub_sum[WIDTH-1:0];
        cout_d = sub_sum[WIDTH];
        ovf_d  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:   y_d = A << shamt;
      OP_SRL:   y_d = A >> shamt;
      OP_SRA:   y_d = WIDTH'($signed(A) >>> shamt);
      OP_SLT:   y_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_PASSB: y_d = B;
      default:  y_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      if (is_iterative(sel)) begin
        state_q <= ST_BUSY;
      end else begin
        state_q <= ST_DONE;
        y_q     <= y_d;
        cout_q  <= cout_d;
        neg_q   <= y_d[WIDTH-1];
        zero_q  <= (y_d == '0);
        ovf_q   <= ovf_d;
      end
    end else begin
      case (state_q)
        ST_BUSY: if (iter_done) begin
          state_q <= ST_DONE;
          y_q     <= iter_res;
          cout_q  <= 1'b0;
          neg_q   <= iter_res[WIDTH-1];
          zero_q  <= (iter_res == '0);
          ovf_q   <= 1'b0;
        end
        ST_DONE: if (out_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
